// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared width helpers, pointer wrap and read-mode constants for sync_fifo.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int C_FWFT_OFF = 0;
   localparam int C_FWFT_ON  = 1;

   // Width needed to hold 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Wrap by explicit compare so non-power-of-two depths work.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
      return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_ram.sv
// ============================================================================
// Module   : sync_fifo_ram
// Purpose  : WIDTH x DEPTH simple dual-port RAM, one write port, registered read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_ram #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // The array itself is never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output register holds its value until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO, any depth >= 2, standard or FWFT read, registered flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH        = 64,
   parameter int DEPTH        = 1024,
   parameter int FWFT         = C_FWFT_OFF,
   parameter int ALMOST_FULL  = DEPTH - 2,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wren,
   input  logic [WIDTH-1:0]              wrdata,
   input  logic                          rden,
   output logic [WIDTH-1:0]              rddata,
   output logic                          rdvalid,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          wr_err,
   output logic                          rd_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [AW-1:0] wraddr_q, wraddr_d;
   logic [AW-1:0] rdaddr_q, rdaddr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] ram_count;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          almost_full_q, almost_full_d;
   logic          almost_empty_q, almost_empty_d;
   logic          rdvalid_q, rdvalid_d;
   logic          wr_err_q, wr_err_d;
   logic          rd_err_q, rd_err_d;
   logic          out_valid_q, out_valid_d;
   logic          pop;
   logic          push;
   logic          ram_re;

   always_comb begin
      pop         = rden && !empty_q;
      push        = wren && (!full_q || pop);
      // In FWFT the RAM output register is the head slot, counted in count_q.
      ram_count   = count_q - CW'(out_valid_q);
      ram_re      = pop;
      out_valid_d = 1'b0;
      if (FWFT == C_FWFT_ON) begin
         ram_re      = (ram_count != '0) && (!out_valid_q || pop);
         out_valid_d = ram_re || (out_valid_q && !pop);
      end

      wraddr_d = push   ? AW'(ptr_inc(32'(wraddr_q), DEPTH)) : wraddr_q;
      rdaddr_d = ram_re ? AW'(ptr_inc(32'(rdaddr_q), DEPTH)) : rdaddr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      full_d         = (count_d == CW'(DEPTH));
      almost_full_d  = (count_d >= CW'(ALMOST_FULL));
      almost_empty_d = (count_d <= CW'(ALMOST_EMPTY));
      empty_d        = (FWFT == C_FWFT_ON) ? !out_valid_d : (count_d == '0);
      rdvalid_d      = (FWFT == C_FWFT_ON) ? 1'b0 : pop;
      wr_err_d       = wren && !push;
      rd_err_d       = rden && !pop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wraddr_q       <= '0;
         rdaddr_q       <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         rdvalid_q      <= 1'b0;
         wr_err_q       <= 1'b0;
         rd_err_q       <= 1'b0;
         out_valid_q    <= 1'b0;
      end else begin
         wraddr_q       <= wraddr_d;
         rdaddr_q       <= rdaddr_d;
         count_q        <= count_d;
         full_q         <= full_d;
         empty_q        <= empty_d;
         almost_full_q  <= almost_full_d;
         almost_empty_q <= almost_empty_d;
         rdvalid_q      <= rdvalid_d;
         wr_err_q       <= wr_err_d;
         rd_err_q       <= rd_err_d;
         out_valid_q    <= out_valid_d;
      end
   end

   sync_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (push),
      .waddr (wraddr_q),
      .wdata (wrdata),
      .re    (ram_re),
      .raddr (rdaddr_q),
      .rdata (rddata)
   );

   assign rdvalid      = (FWFT == C_FWFT_ON) ? !empty_q : rdvalid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
   assign count        = count_q;
   assign wr_err       = wr_err_q;
   assign rd_err       = rd_err_q;

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock FIFO; the parametrised successor to the dual-clock FIFO in the memory/fifo library.
- Uses every storage slot: full means DEPTH entries held.
- Adds non-power-of-two depth, standard/first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty, and overflow/underflow error pulses.
- Sits between same-clock producer/consumer stages, e.g. sample buffering ahead of the USB/FT245 path.

Parameters:
- WIDTH, 64: data word width in bits.
- DEPTH, 1024: number of entries, any integer >= 2 (need not be a power of two).
- FWFT, 0: 0 = standard read (data one cycle after rden); 1 = head word presented on rddata whenever !empty.
- ALMOST_FULL, DEPTH-2: almost_full asserted when count >= ALMOST_FULL.
- ALMOST_EMPTY, 2: almost_empty asserted when count <= ALMOST_EMPTY.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- wren  in  1  write request.
- wrdata  in  WIDTH  write word.
- rden  in  1  read/pop request.
- rddata  out  WIDTH  read word.
- rdvalid  out  1  standard mode: rddata valid this cycle; FWFT: equals !empty.
- full  out  1  count == DEPTH.
- empty  out  1  no word available to the reader.
- almost_full  out  1  count >= ALMOST_FULL.
- almost_empty  out  1  count <= ALMOST_EMPTY.
- count  out  $clog2(DEPTH+1)  words held, including the FWFT output register.
- wr_err  out  1  one-cycle pulse: write dropped.
- rd_err  out  1  one-cycle pulse: read dropped.

Behaviour:
- Reset (asynchronous, active-high):
  - wraddr, rdaddr, count = 0; rddata = 0.
  - full, rdvalid, almost_full, wr_err, rd_err = 0.
  - empty = 1; almost_empty = 1.
  - Reset mid-operation discards all contents; RAM contents are not cleared.
- Pointer rules:
  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 by explicit compare, not modulo 2^n.
  - Occupancy is tracked by count, not by pointer difference.
- Write acceptance:
  - Accepted when wren && (!full || pop_accepted), where pop_accepted is a read accepted in the same cycle.
  - wren && full && !pop_accepted -> write dropped, wr_err pulses next cycle, state unchanged.
- Read acceptance:
  - Accepted when rden && !empty.
  - rden && empty -> rd_err pulses next cycle, state unchanged.
  - Simultaneous write and read on empty: the write is accepted and the read is rejected with rd_err.
- count arithmetic:
  - +1 on write only, -1 on read only, unchanged on both.
  - count never exceeds DEPTH and never underflows.
- Flags: full, almost_full and almost_empty are registered and valid the cycle after the count change. There is no combinational path from wren/rden to flags.
- Standard mode (FWFT=0):
  - An accepted read drives rddata from RAM[rdaddr] on the next edge with rdvalid=1 for exactly that cycle.
  - rddata holds its last value otherwise.
  - empty = (count == 0), registered.
  - Write-to-readable latency: 1 cycle.
- FWFT mode (FWFT=1):
  - A one-entry output register holds the head; rddata is valid whenever !empty.
  - An accepted rden pops the head; the next word loads the same edge if RAM is non-empty, otherwise empty asserts.
  - Write into an empty FIFO: empty deasserts 2 cycles after the write edge (RAM write, then prefetch).
  - count includes the output register; full remains count == DEPTH.
- Memory: simple dual-port, registered read, inferred block RAM; no reset on the array.

Decomposition:
- Shared package (fifo_pkg): count-width function clog2(DEPTH+1), pointer-increment-with-wrap function, FWFT mode constants.
- One sub-module: sync_fifo_ram (WIDTH x DEPTH, one write port, one registered read port, single clk).
- Pointer, count, flag and FWFT output-stage logic stay in sync_fifo.

Test Plan (WIDTH=16, DEPTH=6, ALMOST_FULL=5, ALMOST_EMPTY=1):
- Reset, then write 0x0001..0x0006 on consecutive cycles:
  - count steps 1..6.
  - almost_empty drops once count reaches 2.
  - almost_full rises when count reaches 5.
  - full=1 after the 6th write.
  - A 7th write 0x0007 gives wr_err pulse, count stays 6.
- From full, read 8 times (standard mode):
  - rddata = 0x0001..0x0006 each one cycle after rden, rdvalid high on those 6 cycles.
  - The 7th and 8th reads each give an rd_err pulse.
  - empty=1, count=0.
- Wrap check: 20 interleaved write/read pairs with count held at 3:
  - Output order matches input across pointer wraps 5 -> 0.
  - full is never asserted; count stays 3.
- Full with simultaneous wren+rden, data 0x00AA:
  - Both accepted, no wr_err, count stays 6.
  - 0x00AA emerges as the 6th subsequent read.
- FWFT=1, write 0x1234 into empty:
  - empty deasserts 2 cycles later with rddata=0x1234 and no rden.
  - rden pops it; empty=1 the next cycle.
- Assert rst asynchronously (between clk edges) with count=4:
  - Outputs reach reset values immediately, without waiting for a clock edge.
  - After release, a read gives rd_err and a write of 0x0BEE reads back as 0x0BEE.
